sim_ctrl_mmio: RTL
==================

# sim_ctrl_mmio

Memory-mapped simulation-control peripheral on the core's 16-bit data bus. It turns program writes into end-of-test status, a console character stream and a cycle watchdog. The bench's logging and timeout tasks consume its outputs rather than inferring pass/fail from the core. It sits between the core's load/store port and the testbench and is synthesizable. On silicon it behaves as an inert register block.

## Interface
- BASE_ADDR, 16'hFF00, word address of register 0; the window is BASE_ADDR..BASE_ADDR+3.
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2.
- WDOG_DEFAULT, 1000, watchdog reload value out of reset. Matches the bench timeout cycle count.

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  bus request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address
- req_wdata  in  16  write data
- rsp_valid  out  1  read data valid
- rsp_rdata  out  16  read data
- console_valid  out  1  FIFO head byte available
- console_data  out  8  FIFO head byte
- console_ready  in  1  bench pops the head byte
- done  out  1  sticky; test has ended (pass, fail or timeout)
- pass  out  1  sticky; valid only when done is high
- fail_code  out  15  code written by the program; 0 on pass or timeout
- timeout  out  1  sticky; watchdog expired

## Operation
Register offsets are relative to BASE_ADDR.
- 0 STATUS
  - Write with wdata[0]=1 ends the test.
  - If wdata[15:1]==0 the result is pass; otherwise it is fail with fail_code=wdata[15:1].
  - Writes with wdata[0]=0 are ignored. Reads return {fail_code, done}.
- 1 CONSOLE
  - A write pushes wdata[7:0] into the FIFO.
  - A read returns {count, 7'b0, full}, where count is the FIFO occupancy zero-extended to 8 bits.
- 2 WATCHDOG
  - A write loads the counter. Writing 0 disables it.
  - A read returns the current count.
- 3 CYCLE
  - Free-running 16-bit cycle counter. Wraps from 16'hFFFF to 0.
  - Writes are ignored.
- Any address outside the window: writes are ignored and reads return 16'h0000 with the normal response.

Outcome FSM, states RUN, PASS, FAIL, TIMEOUT:
- RUN → PASS or FAIL on an accepted end-of-test STATUS write.
- RUN → TIMEOUT when the watchdog expires.
- PASS, FAIL and TIMEOUT are terminal until reset. Later STATUS writes are ignored.
- done = (state != RUN). pass = (state == PASS). timeout = (state == TIMEOUT).

Watchdog:
- Decrements by 1 each cycle while it is nonzero and the state is RUN.
- The 1→0 decrement is the expiry event. It holds at 0 afterwards.

## Timing
Reset values:
- req_ready=1, rsp_valid=0, rsp_rdata=0.
- console_valid=0, console_data=0.
- done=0, pass=0, fail_code=0, timeout=0.
- FIFO empty, cycle counter=0, watchdog=WDOG_DEFAULT, state RUN.

Handshake:
- A request is accepted when req_valid && req_ready.
- Read response: rsp_valid pulses for exactly 1 cycle, the cycle after acceptance, with rsp_rdata registered. rsp_rdata holds its value otherwise.
- Write effects are visible on outputs the cycle after acceptance.
- Back-to-back requests are allowed every cycle.

Console backpressure:
- req_ready = !(req_valid && req_we && addr==CONSOLE && full). This is combinational from req_* and the registered full flag.
- A pop on the same cycle does not lift backpressure.
- Pop occurs when console_valid && console_ready. A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- console_data is the registered head. Push-to-valid latency is 1 cycle.

Simultaneous events:
- A watchdog write coinciding with expiry: the write wins and no timeout occurs.
- A STATUS end-of-test write coinciding with watchdog expiry: the STATUS write wins.

Reset mid-operation:
- rst_n low clears all state asynchronously, including FIFO contents and any in-flight response.

## Structure
- tb_pkg gains:
  - the register offset constants REG_STATUS=0, REG_CONSOLE=1, REG_WDOG=2, REG_CYCLE=3;
  - the outcome enum {RUN, PASS, FAIL, TIMEOUT}.
- The bench's timeout and logging tasks consume done, pass, fail_code, timeout and the console stream.
- One sub-module: sync_fifo, parameterised on width and depth.
  - Ports: push, pop, data in, head out, full, empty, count.
  - Reused for console buffering elsewhere.
- The top holds the address decode, FSM, watchdog, cycle counter and response register.

## Test plan
- Write STATUS=16'h0001 → next cycle done=1, pass=1, fail_code=0. A later write of 16'h0007 leaves all outputs unchanged.
- Write STATUS=16'h000B → done=1, pass=0, fail_code=15'd5. A STATUS read then returns 16'h000B.
- Hold console_ready=0 and write CONSOLE with 'A'..'I' (9 writes, FIFO_DEPTH=8):
  - the 9th write sees req_ready=0 until the first pop;
  - raising console_ready drains 'A'..'I' in order.
- Write WATCHDOG=5 and idle → timeout=1 and done=1 exactly 5 cycles after the write takes effect. A later write WATCHDOG=0 with no expiry leaves timeout=0.
- Read CYCLE across the wrap point → 16'hFFFF then 16'h0000. Each read gives rsp_valid for 1 cycle, 1 cycle after acceptance.
- Assert rst_n low mid-drain with 3 bytes queued and done=1 → all outputs return to reset values immediately, and the watchdog reads back WDOG_DEFAULT.

Source files
------------

// File: rtl/sim_ctrl_mmio_pkg.sv
// Shared definitions for the simulation-control peripheral.
// Holds the register offsets within the four-word window, the
// end-of-test outcome encoding and a helper that packs the CONSOLE
// status word.
package sim_ctrl_mmio_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONSOLE = 2'd1;
    localparam logic [1:0] REG_WDOG    = 2'd2;
    localparam logic [1:0] REG_CYCLE   = 2'd3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } outcome_e;

    // CONSOLE read word: occupancy in the upper byte, full flag in bit 0.
    function automatic logic [15:0] console_status(input logic [7:0] count,
                                                   input logic       full);
        return {count, 7'b0, full};
    endfunction

endpackage

// File: rtl/sim_ctrl_mmio_sync_fifo.sv
// Single-clock FIFO with a registered head word.
// Ports:
//   clk, rst_n     clock, async active-low reset (clears contents)
//   push_i, data_i write side; a push while full is dropped
//   pop_i          read side; a pop while empty is dropped
//   head_o         registered oldest entry, 0 when empty
//   full_o/empty_o occupancy flags
//   count_o        occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = head_q;
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        // The head register must already hold the next entry on the cycle
        // after a pop, so the successor is read out of the array here.
        head_d = head_q;
        if (do_pop) begin
            if (count_q == CW'(1)) begin
                head_d = do_push ? data_i : '0;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end else if (empty_o && do_push) begin
            head_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/sim_ctrl_mmio.sv
// Memory-mapped simulation-control peripheral on the 16-bit data bus.
// Converts program stores into end-of-test status, a console byte stream
// and a cycle watchdog; inert on silicon.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid_i/req_ready_o    request handshake (ready drops only for a
//                              console push into a full FIFO)
//   req_we_i, req_addr_i,
//   req_wdata_i                request payload (word address)
//   rsp_valid_o, rsp_rdata_o   one-cycle read response, data held after
//   console_valid_o/_data_o,
//   console_ready_i            console byte stream (registered head)
//   done_o, pass_o, fail_code_o,
//   timeout_o                  sticky end-of-test outcome
//
// state   | meaning
// --------+--------------------------------------------
// RUN     | test in progress, watchdog may count
// PASS    | program reported success (terminal)
// FAIL    | program reported a nonzero fail code (terminal)
// TIMEOUT | watchdog expired before any report (terminal)
module sim_ctrl_mmio
    import sim_ctrl_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] WDOG_DEFAULT = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        console_valid_o,
    output logic [7:0]  console_data_o,
    input  logic        console_ready_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [14:0] fail_code_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    outcome_e    state_q, state_d;
    logic [14:0] fail_code_q, fail_code_d;
    logic [15:0] wdog_q, wdog_d;
    logic [15:0] cycle_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q, rdata_d;

    logic [15:0]   offset;
    logic          in_win;
    logic [1:0]    reg_sel;
    logic          accept, wr_en, rd_en;
    logic          status_end_wr, console_push, console_pop, wdog_wr, wdog_expire;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    // Subtracting the base makes every address below it wrap to a large
    // offset, so a single upper-bits test covers both sides of the window.
    assign offset  = req_addr_i - BASE_ADDR;
    assign in_win  = (offset[15:2] == 14'd0);
    assign reg_sel = offset[1:0];

    // Backpressure looks only at the registered full flag; a pop in the
    // same cycle does not make room for this push.
    assign req_ready_o = !(req_valid_i && req_we_i && in_win &&
                           (reg_sel == REG_CONSOLE) && fifo_full);

    assign accept        = req_valid_i && req_ready_o;
    assign wr_en         = accept && req_we_i && in_win;
    assign rd_en         = accept && !req_we_i;
    assign status_end_wr = wr_en && (reg_sel == REG_STATUS) && req_wdata_i[0];
    assign console_push  = wr_en && (reg_sel == REG_CONSOLE);
    assign wdog_wr       = wr_en && (reg_sel == REG_WDOG);
    assign console_pop   = console_valid_o && console_ready_i;

    // A reload in the expiry cycle cancels the expiry.
    assign wdog_expire = (state_q == RUN) && (wdog_q == 16'd1) && !wdog_wr;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (console_push),
        .pop_i   (console_pop),
        .data_i  (req_wdata_i[7:0]),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The STATUS report is checked before expiry so a report landing on
    // the expiry cycle wins.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        case (state_q)
            RUN: begin
                if (status_end_wr) begin
                    if (req_wdata_i[15:1] == 15'd0) begin
                        state_d = PASS;
                    end else begin
                        state_d     = FAIL;
                        fail_code_d = req_wdata_i[15:1];
                    end
                end else if (wdog_expire) begin
                    state_d = TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wdog_d = wdog_q;
        if (wdog_wr) begin
            wdog_d = req_wdata_i;
        end else if ((state_q == RUN) && (wdog_q != 16'd0)) begin
            wdog_d = wdog_q - 16'd1;
        end
    end

    always_comb begin
        rdata_d = 16'h0000;
        if (in_win) begin
            case (reg_sel)
                REG_STATUS:  rdata_d = {fail_code_q, state_q != RUN};
                REG_CONSOLE: rdata_d = console_status(8'(fifo_count), fifo_full);
                REG_WDOG:    rdata_d = wdog_q;
                REG_CYCLE:   rdata_d = cycle_q;
                default:     rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fail_code_q <= '0;
            wdog_q      <= WDOG_DEFAULT;
            cycle_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
            wdog_q      <= wdog_d;
            cycle_q     <= cycle_q + 16'd1;
            rsp_valid_q <= rd_en;
            if (rd_en) begin
                rsp_rdata_q <= rdata_d;
            end
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign console_valid_o = !fifo_empty;
    assign console_data_o  = fifo_head;
    assign done_o          = (state_q != RUN);
    assign pass_o          = (state_q == PASS);
    assign timeout_o       = (state_q == TIMEOUT);
    assign fail_code_o     = fail_code_q;

endmodule
